// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle SLL/SRL/SRA/ROR sequencer iterating a narrow shift stage.
// Optional build macro SHIFT_SEQ_BIGSTEP_EN adds a shift-by-8 stage to shorten long shifts.
module shift_seq_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        abort,
    input  logic        result_ack,
    output logic        ready,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t      state_r;
    logic [31:0] acc_r;
    logic [4:0]  rem_r;
    logic [1:0]  op_r;
    logic        ready_r;
    logic        busy_r;
    logic        valid_r;

    logic [4:0]  step_k_s;
    logic [31:0] acc_step_s;
    logic [4:0]  rem_next_s;

    function automatic logic [31:0] step1(input logic [31:0] a, input logic [1:0] o);
        logic [31:0] r;
        case (o)
            OP_SLL:  r = {a[30:0], 1'b0};
            OP_SRL:  r = {1'b0, a[31:1]};
            OP_SRA:  r = {a[31], a[31:1]};
            OP_ROR:  r = {a[0], a[31:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] step2(input logic [31:0] a, input logic [1:0] o);
        logic [31:0] r;
        case (o)
            OP_SLL:  r = {a[29:0], 2'b00};
            OP_SRL:  r = {2'b00, a[31:2]};
            OP_SRA:  r = {{2{a[31]}}, a[31:2]};
            OP_ROR:  r = {a[1:0], a[31:2]};
            default: r = a;
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_BIGSTEP_EN
    function automatic logic [31:0] step8(input logic [31:0] a, input logic [1:0] o);
        logic [31:0] r;
        case (o)
            OP_SLL:  r = {a[23:0], 8'h00};
            OP_SRL:  r = {8'h00, a[31:8]};
            OP_SRA:  r = {{8{a[31]}}, a[31:8]};
            OP_ROR:  r = {a[7:0], a[31:8]};
            default: r = a;
        endcase
        return r;
    endfunction
`endif

    // Pick the largest stage that fits the remaining count so rem never underflows.
    always_comb begin
        step_k_s   = 5'd0;
        acc_step_s = acc_r;
`ifdef SHIFT_SEQ_BIGSTEP_EN
        if (rem_r >= 5'd8) begin
            step_k_s   = 5'd8;
            acc_step_s = step8(acc_r, op_r);
        end else if (rem_r >= 5'd2) begin
`else
        if (rem_r >= 5'd2) begin
`endif
            step_k_s   = 5'd2;
            acc_step_s = step2(acc_r, op_r);
        end else if (rem_r == 5'd1) begin
            step_k_s   = 5'd1;
            acc_step_s = step1(acc_r, op_r);
        end else begin
            step_k_s   = 5'd0;
            acc_step_s = acc_r;
        end
        rem_next_s = rem_r - step_k_s;
    end

    // Sequencer FSM; handshake flags are registered alongside the state they decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            acc_r   <= 32'h0000_0000;
            rem_r   <= 5'd0;
            op_r    <= 2'b00;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r   <= data_in;
                        rem_r   <= shamt;
                        op_r    <= op;
                        ready_r <= 1'b0;
                        if (shamt != 5'd0) begin
                            state_r <= ST_SHIFT;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_r <= acc_step_s;
                    rem_r <= rem_next_s;
                    if (rem_next_s == 5'd0) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here, even alongside result_ack.
                    if (result_ack) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_r;
    assign busy         = busy_r;
    assign result_valid = valid_r;
    assign result       = acc_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed plan vectors plus randomized operations vs. an arithmetic model.
// Latency expectations follow SHIFT_SEQ_BIGSTEP_EN when it is defined for the build.
module tb_shift_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        abort;
    logic        result_ack;
    logic        ready;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int vec_cnt = 0;
    int err_cnt = 0;

    shift_seq_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .data_in(data_in), .shamt(shamt), .abort(abort), .result_ack(result_ack),
        .ready(ready), .busy(busy), .result_valid(result_valid), .result(result)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    // Edges from accept (inclusive) until result_valid is seen.
    function automatic int ref_latency(input int s);
`ifdef SHIFT_SEQ_BIGSTEP_EN
        return s / 8 + ((s % 8) + 1) / 2 + 1;
`else
        return (s + 1) / 2 + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                          output int lat, output int busy_cycles);
        op = o; data_in = d; shamt = s; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!result_valid && lat < 40) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vec_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b expected 1", ready); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec_cnt++; if (result_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        vec_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h expected 0", result); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        int lat, bc;
        run_op(2'b10, 32'h8000_0000, 5'd5, lat, bc);
        vec_cnt++; if (result !== 32'hFC00_0000) begin err_cnt++; $display("FAIL sra5_result: got %h expected fc000000", result); end
        vec_cnt++; if (lat !== ref_latency(5)) begin err_cnt++; $display("FAIL sra5_latency: got %0d expected %0d", lat, ref_latency(5)); end
        vec_cnt++; if (bc !== ref_latency(5) - 1) begin err_cnt++; $display("FAIL sra5_busy: got %0d expected %0d", bc, ref_latency(5) - 1); end
        ack_result();
        vec_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL sra5_ready_after_ack: got %b expected 1", ready); end
        tick();

        run_op(2'b01, 32'h8000_0000, 5'd31, lat, bc);
        vec_cnt++; if (result !== 32'h0000_0001) begin err_cnt++; $display("FAIL srl31_result: got %h expected 00000001", result); end
        vec_cnt++; if (lat !== ref_latency(31)) begin err_cnt++; $display("FAIL srl31_latency: got %0d expected %0d", lat, ref_latency(31)); end
        ack_result();
        tick();

        run_op(2'b00, 32'h0000_0001, 5'd0, lat, bc);
        vec_cnt++; if (result !== 32'h0000_0001) begin err_cnt++; $display("FAIL sll0_result: got %h expected 00000001", result); end
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL sll0_latency: got %0d expected 1", lat); end
        vec_cnt++; if ((bc !== 0) || (busy !== 1'b0)) begin err_cnt++; $display("FAIL sll0_busy: got %0d cycles expected 0", bc); end
        ack_result();
        tick();

        run_op(2'b11, 32'h0000_0003, 5'd1, lat, bc);
        vec_cnt++; if (result !== 32'h8000_0001) begin err_cnt++; $display("FAIL ror1_result: got %h expected 80000001", result); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt++; if (result_valid !== 1'b1) begin err_cnt++; $display("FAIL ror1_hold_valid: got %b expected 1", result_valid); end
            vec_cnt++; if (result !== 32'h8000_0001) begin err_cnt++; $display("FAIL ror1_hold_result: got %h expected 80000001", result); end
        end
        ack_result();
        vec_cnt++; if (ready !== 1'b1 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL ror1_ack: got ready=%b valid=%b expected 1/0", ready, result_valid); end
        tick();
    endtask

    task automatic test_random();
        int lat, bc, s;
        logic [1:0]  o;
        logic [31:0] d, exp_v;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            d = $urandom;
            s = $urandom_range(0, 31);
            exp_v = ref_shift(o, d, s);
            run_op(o, d, 5'(s), lat, bc);
            vec_cnt++; if (result !== exp_v) begin err_cnt++; $display("FAIL rand_result op=%0d d=%h s=%0d: got %h expected %h", o, d, s, result, exp_v); end
            vec_cnt++; if (lat !== ref_latency(s)) begin err_cnt++; $display("FAIL rand_latency s=%0d: got %0d expected %0d", s, lat, ref_latency(s)); end
            repeat ($urandom_range(0, 2)) tick();
            ack_result();
            vec_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL rand_ready: got %b expected 1", ready); end
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_abort();
        int lat, bc, seen;
        logic [31:0] part;
`ifdef SHIFT_SEQ_BIGSTEP_EN
        part = ref_shift(2'b10, 32'hF000_0000, 16);
`else
        part = ref_shift(2'b10, 32'hF000_0000, 4);
`endif
        op = 2'b10; data_in = 32'hF000_0000; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
        abort = 1'b1;
        result_ack = 1'b1;
        tick();
        abort = 1'b0;
        result_ack = 1'b0;
        vec_cnt++; if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_idle: got r/b/v=%b%b%b expected 100", ready, busy, result_valid); end
        vec_cnt++; if (result !== part) begin err_cnt++; $display("FAIL abort_acc: got %h expected %h", result, part); end
        seen = 0;
        repeat (12) begin tick(); if (result_valid) seen++; end
        vec_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end

        run_op(2'b00, 32'h0000_0001, 5'd4, lat, bc);
        vec_cnt++; if (result !== 32'h0000_0010) begin err_cnt++; $display("FAIL post_abort_sll: got %h expected 00000010", result); end
        abort = 1'b1; result_ack = 1'b1;
        tick();
        abort = 1'b0; result_ack = 1'b0;
        vec_cnt++; if (ready !== 1'b1 || result_valid !== 1'b0 || result !== 32'h0000_0010) begin err_cnt++; $display("FAIL abort_ack_done: got r/v=%b%b res=%h expected 1/0 00000010", ready, result_valid, result); end
        tick();
    endtask

    task automatic test_async_reset();
        op = 2'b10; data_in = 32'h9ABC_DEF1; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        vec_cnt++; if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin err_cnt++; $display("FAIL async_reset_flags: got r/b/v=%b%b%b expected 100", ready, busy, result_valid); end
        vec_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL async_reset_result: got %h expected 0", result); end
        #1;
        reset_n = 1'b1;
        tick();
        vec_cnt++; if (ready !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL post_reset_idle: got r/b=%b%b expected 10", ready, busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] first_v, second_v;
        first_v  = ref_shift(2'b00, 32'h1234_5678, 3);
        second_v = ref_shift(2'b11, 32'hA5A5_0F0F, 0);
        run_op(2'b00, 32'h1234_5678, 5'd3, lat, bc);
        op = 2'b11; data_in = 32'hA5A5_0F0F; shamt = 5'd0; start = 1'b1;
        result_ack = 1'b0;
        repeat (3) begin
            tick();
            vec_cnt++; if (result_valid !== 1'b1 || ready !== 1'b0 || result !== first_v) begin err_cnt++; $display("FAIL done_start_held: got v/r=%b%b res=%h expected 1/0 %h", result_valid, ready, result, first_v); end
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        vec_cnt++; if (ready !== 1'b1 || result_valid !== 1'b0 || result !== first_v) begin err_cnt++; $display("FAIL done_ack_with_start: got r/v=%b%b res=%h expected 1/0 %h", ready, result_valid, result, first_v); end
        tick();
        start = 1'b0;
        vec_cnt++; if (result_valid !== 1'b1 || result !== second_v) begin err_cnt++; $display("FAIL held_start_accept: got v=%b res=%h expected 1 %h", result_valid, result, second_v); end
        ack_result();
        tick();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; data_in = 32'h0;
        shamt = 5'd0; abort = 1'b0; result_ack = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
